// File: rtl/fwrisc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwrisc_mem_pkg
//  Brief    : Shared types and helpers for the fwrisc memory sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package fwrisc_mem_pkg;

    // Access width as encoded by the execute stage; 2'b11 is illegal
    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BUS  = 3'd1,
        WB   = 3'd2,
        FIN  = 3'd3,
        ERR  = 3'd4
    } mem_state_e;

    // An access is rejected when it is not naturally aligned or has an illegal size
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic r;
        case (mem_size_e'(size))
            MEM_B:   r = 1'b0;
            MEM_H:   r = addr[0];
            MEM_W:   r = (addr != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwrisc_mem_align.sv
`default_nettype none
// ============================================================================
//  Module   : fwrisc_mem_align
//  Brief    : Byte-lane strobes, store-data replication and load extraction /
//             sign or zero extension for the memory sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module fwrisc_mem_align
    import fwrisc_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_aligned,
    output logic [31:0] rdata_ext
);

    logic [31:0] w_lane;

    // Lane selection and extension; illegal sizes yield zeros (never reach the bus)
    always_comb begin
        strb          = 4'b0000;
        wdata_aligned = 32'h0;
        rdata_ext     = 32'h0;
        w_lane        = rdata >> {addr, 3'b000};
        case (mem_size_e'(size))
            MEM_B: begin
                strb          = 4'b0001 << addr;
                wdata_aligned = {4{wdata[7:0]}};
                rdata_ext     = {{24{w_lane[7] & ~uns}}, w_lane[7:0]};
            end
            MEM_H: begin
                strb          = 4'b0011 << addr;
                wdata_aligned = {2{wdata[15:0]}};
                rdata_ext     = {{16{w_lane[15] & ~uns}}, w_lane[15:0]};
            end
            MEM_W: begin
                strb          = 4'b1111;
                wdata_aligned = wdata;
                rdata_ext     = rdata;
            end
            default: begin
                strb          = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fwrisc_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fwrisc_mem_sequencer
//  Brief    : Sequences execute-stage loads/stores onto the single-master
//             memory bus, with bus timeout and register write-back.
//  Revision : 1.0 - initial release
// ============================================================================
module fwrisc_mem_sequencer
    import fwrisc_mem_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [5:0]  req_rd,
    output logic        mvalid,
    output logic        mwrite,
    output logic [31:0] maddr,
    output logic [31:0] mdata,
    output logic [3:0]  mstrb,
    input  logic        mready,
    input  logic [31:0] mrdata,
    output logic        rd_write,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        done,
    output logic        fault
);

    mem_state_e  r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [5:0]  r_rd;
    logic [31:0] r_rdata;
    logic [31:0] r_cnt;

    logic [3:0]  w_strb;
    logic [31:0] w_wdata_aligned;
    logic [31:0] w_rdata_ext;
    logic [31:0] w_cnt_next;
    logic        w_timeout;
    logic        w_in_bus;
    logic        w_in_wb;

    fwrisc_mem_align u_align (
        .size          (r_size),
        .addr          (r_addr[1:0]),
        .uns           (r_unsigned),
        .wdata         (r_wdata),
        .rdata         (mrdata),
        .strb          (w_strb),
        .wdata_aligned (w_wdata_aligned),
        .rdata_ext     (w_rdata_ext)
    );

    // Timeout fires on the wait cycle that brings the count up to the limit
    always_comb begin
        w_cnt_next = r_cnt + 32'd1;
        w_timeout  = (BUS_TIMEOUT != 0) && (w_cnt_next >= BUS_TIMEOUT);
        w_in_bus   = (r_state == BUS);
        w_in_wb    = (r_state == WB);
    end

    // Op capture, state sequencing, timeout counting and load-data capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rd       <= 6'd0;
            r_rdata    <= 32'h0;
            r_cnt      <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_rd       <= req_rd;
                        r_cnt      <= 32'h0;
                        r_state    <= is_misaligned(req_size, req_addr[1:0]) ? ERR : BUS;
                    end
                end
                BUS: begin
                    if (mready) begin
                        if (!r_write) begin
                            r_rdata <= w_rdata_ext;
                        end
                        r_state <= r_write ? FIN : WB;
                    end else begin
                        if (r_cnt != 32'hFFFF_FFFF) begin
                            r_cnt <= w_cnt_next;
                        end
                        if (w_timeout) begin
                            r_state <= ERR;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode purely from registered state, so the bus is clean outside BUS
    always_comb begin
        req_ready = (r_state == IDLE);
        mvalid    = w_in_bus;
        mwrite    = w_in_bus & r_write;
        maddr     = w_in_bus ? {r_addr[31:2], 2'b00} : 32'h0;
        mdata     = (w_in_bus & r_write) ? w_wdata_aligned : 32'h0;
        mstrb     = w_in_bus ? w_strb : 4'b0000;
        rd_write  = w_in_wb & (r_rd != 6'd0);
        rd_waddr  = w_in_wb ? r_rd : 6'd0;
        rd_wdata  = w_in_wb ? r_rdata : 32'h0;
        done      = (r_state == WB) || (r_state == FIN) || (r_state == ERR);
        fault     = (r_state == ERR);
    end

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwrisc_mem_sequencer
//  Brief    : Self-checking bench: directed scenarios plus random ops checked
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fwrisc_mem_sequencer;

    localparam int unsigned TMO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [5:0]  req_rd = 6'd0;
    logic        mvalid;
    logic        mwrite;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [3:0]  mstrb;
    logic        mready = 1'b0;
    logic [31:0] mrdata = 32'h0;
    logic        rd_write;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        done;
    logic        fault;

    int checks = 0;
    int errors = 0;

    fwrisc_mem_sequencer #(.BUS_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mvalid(mvalid), .mwrite(mwrite), .maddr(maddr), .mdata(mdata),
        .mstrb(mstrb), .mready(mready), .mrdata(mrdata),
        .rd_write(rd_write), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .done(done), .fault(fault)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        if (sz == 2'b11) return 1'b1;
        nbytes = 1 << sz;
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
        int lane;
        lane = a % 4;
        if (sz == 2'b00) return 4'(1 << lane);
        if (sz == 2'b01) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_mdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return (d % 256) * 32'h0101_0101;
        if (sz == 2'b01) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a, input logic [31:0] rdat);
        logic [31:0] lane;
        logic [31:0] v;
        lane = rdat / (32'd1 << (8 * (a % 4)));
        if (sz == 2'b00) begin
            v = lane % 256;
            if (!uns && v >= 128) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            v = lane % 65536;
            if (!uns && v >= 32768) v = v - 32'd65536;
        end else begin
            v = rdat;
        end
        return v;
    endfunction

    // Issue one op; mready rises after 'waits' wait cycles. Optionally keep
    // req_valid asserted with junk while busy to prove it is ignored.
    task automatic run_op(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [5:0] rd,
                          input int waits, input logic [31:0] rdat, input bit noisy);
        bit mis;
        bit tmo;
        bit fin;
        mis = m_misaligned(sz, addr);
        tmo = !mis && (TMO != 0) && (waits >= int'(TMO));
        chk({tag, ".ready_idle"}, {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        step();
        if (noisy) begin
            req_addr = ~addr; req_wdata = ~wd; req_write = ~wr;
        end else begin
            req_valid = 1'b0;
        end
        if (mis) begin
            req_valid = 1'b0;
            chk({tag, ".mis_mvalid"}, {31'h0, mvalid}, 32'd0);
            chk({tag, ".mis_done"}, {31'h0, done}, 32'd1);
            chk({tag, ".mis_fault"}, {31'h0, fault}, 32'd1);
            chk({tag, ".mis_rdw"}, {31'h0, rd_write}, 32'd0);
        end else begin
            fin = 1'b0;
            for (int i = 0; i < 64 && !fin; i++) begin
                chk({tag, ".mvalid"}, {31'h0, mvalid}, 32'd1);
                chk({tag, ".ready_busy"}, {31'h0, req_ready}, 32'd0);
                chk({tag, ".maddr"}, maddr, {addr[31:2], 2'b00});
                chk({tag, ".mstrb"}, {28'h0, mstrb}, {28'h0, m_strb(sz, addr)});
                chk({tag, ".mwrite"}, {31'h0, mwrite}, {31'h0, wr});
                if (wr) chk({tag, ".mdata"}, mdata, m_mdata(sz, wd));
                chk({tag, ".done_busy"}, {31'h0, done}, 32'd0);
                if (i == waits) begin
                    mready = 1'b1; mrdata = rdat; req_valid = 1'b0;
                    step();
                    mready = 1'b0; mrdata = $urandom;
                    fin = 1'b1;
                end else begin
                    mready = 1'b0;
                    if (i + 1 >= int'(TMO)) req_valid = 1'b0;
                    step();
                    if (tmo && i + 1 == int'(TMO)) fin = 1'b1;
                end
            end
            if (!fin) chk({tag, ".bus_bound"}, 32'd0, 32'd1);
            chk({tag, ".mvalid_off"}, {31'h0, mvalid}, 32'd0);
            chk({tag, ".done"}, {31'h0, done}, 32'd1);
            chk({tag, ".fault"}, {31'h0, fault}, {31'h0, tmo});
            chk({tag, ".rd_write"}, {31'h0, rd_write}, {31'h0, (!tmo && !wr && rd != 0)});
            if (!tmo && !wr && rd != 0) begin
                chk({tag, ".rd_waddr"}, {26'h0, rd_waddr}, {26'h0, rd});
                chk({tag, ".rd_wdata"}, rd_wdata, m_load(sz, uns, addr, rdat));
            end
        end
        step();
        chk({tag, ".ready_after"}, {31'h0, req_ready}, 32'd1);
        chk({tag, ".done_after"}, {31'h0, done}, 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst.ready", {31'h0, req_ready}, 32'd1);
        chk("rst.mvalid", {31'h0, mvalid}, 32'd0);
        chk("rst.outs", {maddr[31:4], mdata[31:4] ^ 28'h0, mstrb} | {28'h0, mwrite, rd_write, done, fault}, 32'd0);
        chk("rst.rd", {20'h0, rd_waddr, 6'h0} | rd_wdata, 32'd0);
        step();
        reset = 1'b0;
        step();

        // 1: SW word, zero-wait
        run_op("sw_word", 1, 2'b10, 0, 32'h0000_1000, 32'hDEAD_BEEF, 6'd0, 0, 32'h0, 0);
        // 2: LB / LBU upper lane
        run_op("lb",  0, 2'b00, 0, 32'h0000_2003, 32'h0, 6'd5, 0, 32'h8000_0000, 0);
        run_op("lbu", 0, 2'b00, 1, 32'h0000_2003, 32'h0, 6'd5, 0, 32'h8000_0000, 0);
        // 3: SH upper half, misaligned LH
        run_op("sh",  1, 2'b01, 0, 32'h0000_2002, 32'h0000_1234, 6'd0, 0, 32'h0, 0);
        run_op("lh_mis", 0, 2'b01, 0, 32'h0000_2001, 32'h0, 6'd7, 0, 32'h0, 0);
        run_op("size11", 1, 2'b11, 0, 32'h0000_2000, 32'h1, 6'd7, 0, 32'h0, 0);
        // 4: LW to x0 with three wait cycles, busy req_valid ignored
        run_op("lw_x0", 0, 2'b10, 0, 32'h0000_3000, 32'h0, 6'd0, 3, 32'h1234_5678, 1);
        // 5: bus timeout
        run_op("tmo", 0, 2'b10, 0, 32'h0000_4000, 32'h0, 6'd9, 100, 32'h0, 0);

        // 6: reset during BUS wait
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h5000; req_rd = 6'd3;
        step();
        req_valid = 1'b0;
        step();
        chk("rstbus.mvalid_pre", {31'h0, mvalid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstbus.mvalid", {31'h0, mvalid}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("rstbus.ready", {31'h0, req_ready}, 32'd1);
        run_op("post_rst", 0, 2'b01, 0, 32'h0000_6002, 32'h0, 6'd12, 1, 32'h8001_0000, 0);

        // Random ops against the model
        for (int n = 0; n < 60; n++) begin
            bit          wr;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [5:0]  rd;
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            rd = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom);
            run_op("rand", wr, sz, 1'($urandom_range(0, 1)), a, $urandom, rd,
                   $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
